// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction-fetch stage: reset vector,
// fetch exception code and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] EXC_ADEL_IF      = 32'h0000_0004;
  localparam logic [31:0] EXC_NONE         = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// SRAM-like instruction bus between the fetch stage (master) and memory (slave).
// Handshake: inst_req/inst_addr are offered until inst_addr_ok is seen in the same
// cycle; the read word is valid only in the cycle inst_data_ok is high, at most one
// request is ever outstanding, and addr_ok/data_ok never coincide for one request.
interface fetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the PC, runs one bus request at a time and
// hands the fetched word plus PC context to IF/ID, absorbing stalls, redirects and flushes.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                FlushF,
  input  logic [31:0]         FlushPCF,
  input  logic                BranchTakenD,
  input  logic [31:0]         BranchTargetD,
  input  logic                IsBranchD,
  fetch_unit_if.master        inst_bus,
  output logic [31:0]         ReadDataF,
  output logic [31:0]         PCF,
  output logic [31:0]         PCPlus4F,
  output logic [31:0]         PCPlus8F,
  output logic                NextDelaySlotD,
  output logic [31:0]         ExceptionTypeF,
  output logic                ValidF,
  output logic                InstStallF,
  output fetch_state_e        dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         redir_valid_q, redir_valid_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic         ds_flag_q, ds_flag_d;
  logic [31:0]  buf_q, buf_d;

  logic         misaligned;
  logic         advance;
  logic [31:0]  next_pc;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign advance    = en && ValidF;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush while a response is still owed must swallow that response
  always_comb begin
    state_d = state_q;
    if (FlushF) begin
      if ((state_q == WAIT || state_q == DISCARD) && !inst_bus.inst_data_ok) begin
        state_d = DISCARD;
      end else begin
        state_d = REQ;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (!misaligned && inst_bus.inst_addr_ok) state_d = WAIT;
        end
        WAIT: begin
          if (inst_bus.inst_data_ok) state_d = advance ? REQ : HOLD;
        end
        HOLD: begin
          if (advance) state_d = REQ;
        end
        DISCARD: begin
          if (inst_bus.inst_data_ok) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  // Output logic; a misaligned PC never reaches the bus and is delivered as an exception
  always_comb begin
    inst_bus.inst_req = 1'b0;
    ValidF            = 1'b0;
    ReadDataF         = 32'd0;
    ExceptionTypeF    = EXC_NONE;
    case (state_q)
      REQ: begin
        if (misaligned) begin
          ValidF         = 1'b1;
          ExceptionTypeF = EXC_ADEL_IF;
        end else begin
          inst_bus.inst_req = !rst;
        end
      end
      WAIT: begin
        ValidF    = inst_bus.inst_data_ok;
        ReadDataF = inst_bus.inst_rdata;
      end
      HOLD: begin
        ValidF    = 1'b1;
        ReadDataF = buf_q;
      end
      default: begin
        ValidF = 1'b0;
      end
    endcase
  end

  assign next_pc = FlushF        ? FlushPCF      :
                   redir_valid_q ? redir_pc_q    :
                   BranchTakenD  ? BranchTargetD :
                                   pc_q + 32'd4;

  always_comb begin
    pc_d          = pc_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    ds_flag_d     = ds_flag_q;
    buf_d         = buf_q;
    if (FlushF || advance) begin
      pc_d          = next_pc;
      redir_valid_d = 1'b0;
      ds_flag_d     = 1'b0;
    end else begin
      // The branch may leave ID before its delay slot is fetched; remember it here
      if (BranchTakenD) begin
        redir_valid_d = 1'b1;
        redir_pc_d    = BranchTargetD;
      end
      if (IsBranchD) ds_flag_d = 1'b1;
    end
    if (FlushF) begin
      buf_d = 32'd0;
    end else if (state_q == WAIT && inst_bus.inst_data_ok && !advance) begin
      buf_d = inst_bus.inst_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      ds_flag_q     <= 1'b0;
      buf_q         <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      ds_flag_q     <= ds_flag_d;
      buf_q         <= buf_d;
    end
  end

  assign inst_bus.inst_addr = pc_q;
  assign PCF                = pc_q;
  assign PCPlus4F           = pc_q + 32'd4;
  assign PCPlus8F           = pc_q + 32'd8;
  assign NextDelaySlotD     = IsBranchD | ds_flag_q;
  assign InstStallF         = !ValidF;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit: zero-wait fetch, en stall,
// branch delay slot with slow data, flush while waiting, misaligned PC, PC wrap, reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] exc;
    logic        nds;
    logic [1:0]  st;
  } out_t;

  typedef struct {
    logic        en;
    logic        fl;
    logic [31:0] flpc;
    logic        bt;
    logic [31:0] btgt;
    logic        isb;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] B   = 32'hBFC0_0000;
  localparam logic [1:0]  S_R = 2'd0, S_W = 2'd1, S_H = 2'd2, S_D = 2'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en, FlushF, BranchTakenD, IsBranchD;
  logic [31:0]  FlushPCF, BranchTargetD;
  logic [31:0]  ReadDataF, PCF, PCPlus4F, PCPlus8F, ExceptionTypeF;
  logic         NextDelaySlotD, ValidF, InstStallF;
  fetch_state_e dbg_state;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .FlushF         (FlushF),
    .FlushPCF       (FlushPCF),
    .BranchTakenD   (BranchTakenD),
    .BranchTargetD  (BranchTargetD),
    .IsBranchD      (IsBranchD),
    .inst_bus       (bus.master),
    .ReadDataF      (ReadDataF),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F),
    .PCPlus8F       (PCPlus8F),
    .NextDelaySlotD (NextDelaySlotD),
    .ExceptionTypeF (ExceptionTypeF),
    .ValidF         (ValidF),
    .InstStallF     (InstStallF),
    .dbg_state_o    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  task automatic add(input logic e, input logic fl, input logic [31:0] flpc,
                     input logic bt, input logic [31:0] btgt, input logic isb,
                     input logic aok, input logic dok, input logic [31:0] rd,
                     input logic req, input logic [31:0] addr, input logic valid,
                     input logic [31:0] rdo, input logic [31:0] exc, input logic nds,
                     input logic [1:0] st);
    vec_t v;
    v.en = e; v.fl = fl; v.flpc = flpc; v.bt = bt; v.btgt = btgt; v.isb = isb;
    v.aok = aok; v.dok = dok; v.rd = rd;
    v.exp = '{req: req, addr: addr, valid: valid, rdata: rdo, exc: exc, nds: nds, st: st};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    en               = v.en;
    FlushF           = v.fl;
    FlushPCF         = v.flpc;
    BranchTakenD     = v.bt;
    BranchTargetD    = v.btgt;
    IsBranchD        = v.isb;
    bus.inst_addr_ok = v.aok;
    bus.inst_data_ok = v.dok;
    bus.inst_rdata   = v.rd;
  endtask

  task automatic idle();
    en = 1'b1; FlushF = 1'b0; FlushPCF = 32'd0; BranchTakenD = 1'b0;
    BranchTargetD = 32'd0; IsBranchD = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input out_t exp);
    out_t act;
    act = '{req: bus.inst_req, addr: bus.inst_addr, valid: ValidF, rdata: ReadDataF,
            exc: ExceptionTypeF, nds: NextDelaySlotD, st: dbg_state};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row%0d outputs: got req=%b addr=%h valid=%b rdata=%h exc=%h nds=%b st=%0d, required req=%b addr=%h valid=%b rdata=%h exc=%h nds=%b st=%0d",
               idx, act.req, act.addr, act.valid, act.rdata, act.exc, act.nds, act.st,
               exp.req, exp.addr, exp.valid, exp.rdata, exp.exc, exp.nds, exp.st);
    end
    check32($sformatf("row%0d PCF", idx), PCF, exp.addr);
    check32($sformatf("row%0d PCPlus4F", idx), PCPlus4F, exp.addr + 32'd4);
    check32($sformatf("row%0d PCPlus8F", idx), PCPlus8F, exp.addr + 32'd8);
    check32($sformatf("row%0d InstStallF", idx), {31'd0, InstStallF}, {31'd0, !exp.valid});
  endtask

  initial begin
    idle();
    IsBranchD = 1'b1;

    //   en fl flpc           bt btgt           isb aok dok rd              | req addr           v rdata          exc  nds st
    // Zero-wait bus, en=1
    add(1, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           1, B,             0, 32'd0,         0, 0, S_R);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  1, 32'h1111_1111,   0, B,             1, 32'h1111_1111, 0, 0, S_W);
    add(1, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           1, B + 32'd4,     0, 32'd0,         0, 0, S_R);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  1, 32'h2222_2222,   0, B + 32'd4,     1, 32'h2222_2222, 0, 0, S_W);
    add(1, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           1, B + 32'd8,     0, 32'd0,         0, 0, S_R);
    // Data arrives with en low for 3 cycles: buffered in HOLD
    add(0, 0, 32'd0,         0, 32'd0,         0,  0,  1, 32'h3333_3333,   0, B + 32'd8,     1, 32'h3333_3333, 0, 0, S_W);
    add(0, 0, 32'd0,         0, 32'd0,         0,  0,  0, 32'hAAAA_AAAA,   0, B + 32'd8,     1, 32'h3333_3333, 0, 0, S_H);
    add(0, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           0, B + 32'd8,     1, 32'h3333_3333, 0, 0, S_H);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  0, 32'd0,           0, B + 32'd8,     1, 32'h3333_3333, 0, 0, S_H);
    // Taken branch in ID while its delay slot waits 4 cycles for data
    add(1, 0, 32'd0,         1, 32'h8000_1000, 1,  1,  0, 32'd0,           1, B + 32'd12,    0, 32'd0,         0, 1, S_R);
    add(1, 0, 32'd0,         1, 32'h8000_1000, 1,  0,  0, 32'd0,           0, B + 32'd12,    0, 32'd0,         0, 1, S_W);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  0, 32'd0,           0, B + 32'd12,    0, 32'd0,         0, 1, S_W);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  0, 32'd0,           0, B + 32'd12,    0, 32'd0,         0, 1, S_W);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  1, 32'h4444_4444,   0, B + 32'd12,    1, 32'h4444_4444, 0, 1, S_W);
    add(1, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           1, 32'h8000_1000, 0, 32'd0,         0, 0, S_R);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  1, 32'h5555_5555,   0, 32'h8000_1000, 1, 32'h5555_5555, 0, 0, S_W);
    // Flush while waiting: late response is dropped
    add(1, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           1, 32'h8000_1004, 0, 32'd0,         0, 0, S_R);
    add(1, 1, 32'hBFC0_0380, 0, 32'd0,         0,  0,  0, 32'd0,           0, 32'h8000_1004, 0, 32'd0,         0, 0, S_W);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  1, 32'hDEAD_BEEF,   0, 32'hBFC0_0380, 0, 32'd0,         0, 0, S_D);
    add(1, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           1, 32'hBFC0_0380, 0, 32'd0,         0, 0, S_R);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  1, 32'h6666_6666,   0, 32'hBFC0_0380, 1, 32'h6666_6666, 0, 0, S_W);
    // Flush to a misaligned PC: address error, no request
    add(1, 1, 32'h8000_0002, 0, 32'd0,         0,  0,  0, 32'd0,           1, 32'hBFC0_0384, 0, 32'd0,         0, 0, S_R);
    add(0, 0, 32'd0,         0, 32'd0,         0,  0,  0, 32'd0,           0, 32'h8000_0002, 1, 32'd0,         4, 0, S_R);
    add(1, 0, 32'd0,         0, 32'd0,         0,  0,  0, 32'd0,           0, 32'h8000_0002, 1, 32'd0,         4, 0, S_R);
    add(1, 1, 32'hFFFF_FFFC, 0, 32'd0,         0,  0,  0, 32'd0,           0, 32'h8000_0006, 1, 32'd0,         4, 0, S_R);
    // PC at top of address space: PC+4/PC+8 wrap
    add(1, 1, 32'h8000_0010, 0, 32'd0,         0,  0,  0, 32'd0,           1, 32'hFFFF_FFFC, 0, 32'd0,         0, 0, S_R);
    add(1, 0, 32'd0,         0, 32'd0,         0,  1,  0, 32'd0,           1, 32'h8000_0010, 0, 32'd0,         0, 0, S_R);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs(-1, '{req: 1'b0, addr: B, valid: 1'b0, rdata: 32'd0, exc: 32'd0, nds: 1'b1, st: S_R});
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outputs(i, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Reset pulsed while a request is outstanding
    idle();
    check32("pre-reset state", {30'd0, dbg_state}, {30'd0, S_W});
    rst = 1'b1;
    #1;
    check32("reset state", {30'd0, dbg_state}, {30'd0, S_R});
    check32("reset inst_req", {31'd0, bus.inst_req}, 32'd0);
    check32("reset PCF", PCF, B);
    check32("reset ValidF", {31'd0, ValidF}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    check32("post-reset inst_req", {31'd0, bus.inst_req}, 32'd1);
    check32("post-reset inst_addr", bus.inst_addr, B);
    @(posedge clk);
    #1;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h7777_7777;
    @(negedge clk);
    check32("post-reset ValidF", {31'd0, ValidF}, 32'd1);
    check32("post-reset ReadDataF", ReadDataF, 32'h7777_7777);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check32("post-reset PC advance", PCF, B + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS32 core: owns the PC, issues one instruction request at a time on the SRAM-like instruction bus, and presents the fetched word with its PC, PC+4, PC+8, delay-slot flag and fetch exception code to the IF/ID pipeline register. It sits between the instruction memory interface and IF/ID. It absorbs memory latency, downstream stalls, branch redirects and exception flushes, and reports a stall request to the hazard unit.

## Interface
- RESET_PC, 32'hBFC0_0000, PC value after reset.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  IF/ID write enable from the hazard unit; the F instruction advances when en && ValidF.
- FlushF  in  1  exception/ERET redirect, highest priority.
- FlushPCF  in  32  redirect target for FlushF.
- BranchTakenD  in  1  branch/jump in ID is taken; the instruction in F is its delay slot.
- BranchTargetD  in  32  target for BranchTakenD.
- IsBranchD  in  1  ID holds a branch/jump.
- inst_req  out  1  request valid.
- inst_addr  out  32  request address, equals PCF.
- inst_addr_ok  in  1  address accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  read data.
- ReadDataF  out  32  instruction word.
- PCF, PCPlus4F, PCPlus8F  out  32  PC, PC+4, PC+8 (mod 2^32).
- NextDelaySlotD  out  1  F instruction is a delay slot.
- ExceptionTypeF  out  32  fetch exception code, 0 if none.
- ValidF  out  1  F outputs hold a complete instruction this cycle.
- InstStallF  out  1  equals !ValidF; stall request to the hazard unit.

## Operation
- States: REQ (drive request), WAIT (address accepted, awaiting data), HOLD (data buffered, en low), DISCARD (flushed while waiting, drop the response).
- REQ
  - If PCF[1:0]==0: inst_req=1. On inst_addr_ok go to WAIT.
  - If PCF[1:0]!=0: no request. ValidF=1, ReadDataF=0, ExceptionTypeF=EXC_ADEL_IF (32'h0000_0004).
- WAIT
  - On inst_data_ok: ValidF=1 and ReadDataF=inst_rdata that cycle.
  - If the instruction advances, go to REQ. Otherwise capture inst_rdata into the buffer and go to HOLD.
- HOLD: ValidF=1, ReadDataF=buffer. Go to REQ when the instruction advances.
- Advance (en && ValidF): PCF <= next PC. Next PC priority: FlushF ? FlushPCF : redir_valid ? redir_pc : BranchTakenD ? BranchTargetD : PCF+4.
- Redirect latch: BranchTakenD without advance sets redir_valid and redir_pc=BranchTargetD. The latch clears on advance or FlushF.
- Delay-slot flag: ds_flag sets on IsBranchD without advance and clears on advance or FlushF. NextDelaySlotD = IsBranchD | ds_flag.
- FlushF (any state, regardless of en): PCF <= FlushPCF. Redirect latch, ds_flag and buffer are cleared.
  - From WAIT without inst_data_ok the next state is DISCARD. Otherwise the next state is REQ.
- DISCARD: ValidF=0. On inst_data_ok the response is dropped and the state goes to REQ. A further FlushF only updates PCF.
- At most one outstanding request. No request while in WAIT, HOLD or DISCARD.

## Timing
- Reset values: state=REQ, PCF=RESET_PC, PCPlus4F=RESET_PC+4, PCPlus8F=RESET_PC+8, inst_req=0 while rst is high, ReadDataF=0, ValidF=0, ExceptionTypeF=0, NextDelaySlotD=IsBranchD, redir_valid=0, ds_flag=0.
- The first request is issued in the first cycle after rst deasserts.
- Best case: inst_addr_ok in cycle N, inst_data_ok in N+1, ValidF in N+1, next request in N+2. Throughput is one instruction per 2 cycles.
- inst_addr_ok and inst_data_ok are never asserted in the same cycle for this request (bus guarantee).
- Reset asserted mid-transaction returns to REQ immediately. The stale response is the bus's responsibility (the bus is reset together with the core).
- PCPlus4F and PCPlus8F are combinational from PCF and wrap modulo 2^32.

## Structure
- Shared core package holds RESET_PC default, the EXC_ADEL_IF constant and the fetch state enum (REQ, WAIT, HOLD, DISCARD).
- Single module with no sub-modules. The state register, PC register, redirect latch, ds_flag and 32-bit buffer all live in fetch_unit.

## Test plan
- Reset release, en=1, zero-wait bus: requests appear at 0xBFC00000, 0xBFC00004 and 0xBFC00008. ValidF pulses every 2nd cycle with the matching inst_rdata.
- Data arrives with en=0 for 3 cycles: state is HOLD, ReadDataF keeps its value, no new inst_req. PCF advances one cycle after en rises.
- BranchTakenD=1 (target 0x80001000) while the delay slot waits 4 cycles for data: the delay slot is delivered with NextDelaySlotD=1, and the next request goes to 0x80001000.
- FlushF (FlushPCF=0xBFC00380) in WAIT: the late inst_data_ok word is never presented (ValidF stays 0), and the next request goes to 0xBFC00380.
- Flush to 0x80000002: no inst_req, ValidF=1, ExceptionTypeF=32'h4, ReadDataF=0.
- rst pulsed while in WAIT: inst_req=0 during reset, PCF=0xBFC00000, and a fresh request is issued after release.
